sounder_tx_buffer: RTL and testbench

- Transmit-direction counterpart of the RX USB buffer path: accepts 16-bit sample words from the host-side write port and stores them in a word FIFO.
- Pops interleaved I/Q pairs on each DSP sample strobe and presents them to the TX DSP/DAC chain.
- Drives the USB have_space flag and a sticky tx_underrun status.
- Single clock domain (clk64); host words arrive already synchronised into clk_i.

---
 rtl/sounder_pkg.sv | 15 +
 rtl/sounder_word_fifo.sv | 62 ++++++
 rtl/sounder_tx_buffer.sv | 149 ++++++++++++++
 tb/tb_sounder_tx_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sounder_pkg.sv
// Shared definitions for the sounder TX buffer path: FSM state encoding
// and default FIFO geometry.
package sounder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP_I = 2'd1,
        POP_Q = 2'd2,
        UNDER = 2'd3
    } tx_state_t;

    localparam int DEFAULT_DEPTH_LOG2 = 10;
    localparam int DEFAULT_PKT_WORDS  = 256;

endpackage

// File: rtl/sounder_word_fifo.sv
// Single-clock circular word FIFO with synchronous flush, occupancy count and
// full/empty flags. Writes when full and reads when empty are ignored.
module sounder_word_fifo
    import sounder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  wr_i,
    input  logic [15:0]           wr_data_i,
    input  logic                  rd_i,
    output logic [15:0]           rd_data_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  wr_en;
    logic                  rd_en;

    assign full_o    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty_o   = (count == '0);
    assign count_o   = count;
    assign rd_data_o = mem[rd_ptr];

    // Flush takes priority: nothing is stored or consumed in a flush cycle.
    assign wr_en = wr_i & ~full_o & ~flush_i;
    assign rd_en = rd_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (rd_en) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= wr_data_i;
    end

endmodule

// File: rtl/sounder_tx_buffer.sv
// TX sample buffer: host words in, interleaved I/Q pairs out on each DSP strobe.
// Define SOUNDER_TXBUF_DEBUG_EN to build the registered debug_o bus.
module sounder_tx_buffer
    import sounder_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int PKT_WORDS  = DEFAULT_PKT_WORDS
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  enable_i,
    input  logic                  wr_i,
    input  logic [15:0]           wr_data_i,
    output logic                  have_space_o,
    input  logic                  tx_strobe_i,
    output logic [15:0]           tx_i_o,
    output logic [15:0]           tx_q_o,
    output logic                  tx_valid_o,
    input  logic                  clear_status_i,
    output logic                  tx_underrun_o,
    output logic [DEPTH_LOG2:0]   fill_o,
    output logic [15:0]           debug_o
);

    localparam logic [DEPTH_LOG2:0] DEPTH_WORDS = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

    tx_state_t           state, state_next;
    logic [15:0]         i_hold, i_hold_next;
    logic [15:0]         tx_i_next, tx_q_next;
    logic                valid_next, underrun_next;
    logic                pop;
    logic                pair_phase;
    logic [15:0]         fifo_head;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_full, fifo_empty;
    logic [DEPTH_LOG2:0] free_words;

    sounder_word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush_i),
        .wr_i      (wr_i),
        .wr_data_i (wr_data_i),
        .rd_i      (pop & ~fifo_empty),
        .rd_data_o (fifo_head),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign fill_o     = fifo_count;
    assign free_words = DEPTH_WORDS - fifo_count;

    // Underrun only ever emits zeros, so a lone stored word is never split
    // across two output pairs. Setting underrun is ordered after clearing it.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        i_hold_next   = i_hold;
        tx_i_next     = tx_i_o;
        tx_q_next     = tx_q_o;
        valid_next    = 1'b0;
        underrun_next = tx_underrun_o;
        if (clear_status_i) underrun_next = 1'b0;
        if (!enable_i) begin
            state_next = IDLE;
            tx_i_next  = '0;
            tx_q_next  = '0;
        end else if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_strobe_i)
                        state_next = (fifo_count >= (DEPTH_LOG2+1)'(2)) ? POP_I : UNDER;
                end
                POP_I: begin
                    pop         = 1'b1;
                    i_hold_next = fifo_head;
                    state_next  = POP_Q;
                end
                POP_Q: begin
                    pop        = 1'b1;
                    tx_i_next  = i_hold;
                    tx_q_next  = fifo_head;
                    valid_next = 1'b1;
                    state_next = IDLE;
                end
                UNDER: begin
                    tx_i_next     = '0;
                    tx_q_next     = '0;
                    valid_next    = 1'b1;
                    underrun_next = 1'b1;
                    state_next    = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            i_hold        <= '0;
            tx_i_o        <= '0;
            tx_q_o        <= '0;
            tx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            have_space_o  <= 1'b1;
        end else begin
            state         <= state_next;
            i_hold        <= i_hold_next;
            tx_i_o        <= tx_i_next;
            tx_q_o        <= tx_q_next;
            tx_valid_o    <= valid_next;
            tx_underrun_o <= underrun_next;
            have_space_o  <= (free_words >= (DEPTH_LOG2+1)'(PKT_WORDS));
        end
    end

    // Pair phase follows accepted host writes: 0 = next word is I, 1 = Q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            pair_phase <= 1'b0;
        else if (flush_i)
            pair_phase <= 1'b0;
        else if (wr_i && !fifo_full)
            pair_phase <= ~pair_phase;
    end

`ifdef SOUNDER_TXBUF_DEBUG_EN
    logic [15:0] debug_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            debug_q <= '0;
        else
            debug_q <= {state, pair_phase, tx_underrun_o, wr_i, tx_strobe_i, 10'(fifo_count)};
    end

    assign debug_o = debug_q;
`else
    logic debug_unused;
    assign debug_unused = pair_phase;
    assign debug_o      = 16'h0000;
`endif

endmodule

// File: tb/tb_sounder_tx_buffer.sv
// Directed self-checking bench for sounder_tx_buffer (default build).
module tb_sounder_tx_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        enable_i = 1'b1;
    logic        wr_i = 1'b0;
    logic [15:0] wr_data_i = '0;
    logic        have_space_o;
    logic        tx_strobe_i = 1'b0;
    logic [15:0] tx_i_o, tx_q_o;
    logic        tx_valid_o;
    logic        clear_status_i = 1'b0;
    logic        tx_underrun_o;
    logic [10:0] fill_o;
    logic [15:0] debug_o;

    int checks = 0;
    int errors = 0;
    int pairsSeen = 0;
    logic [15:0] expQ[$];

    sounder_tx_buffer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .enable_i       (enable_i),
        .wr_i           (wr_i),
        .wr_data_i      (wr_data_i),
        .have_space_o   (have_space_o),
        .tx_strobe_i    (tx_strobe_i),
        .tx_i_o         (tx_i_o),
        .tx_q_o         (tx_q_o),
        .tx_valid_o     (tx_valid_o),
        .clear_status_i (clear_status_i),
        .tx_underrun_o  (tx_underrun_o),
        .fill_o         (fill_o),
        .debug_o        (debug_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One clock cycle with the given write/strobe inputs, then back to idle inputs.
    task automatic applyStimulus(input logic wr, input logic [15:0] data, input logic strobe);
        wr_i        = wr;
        wr_data_i   = data;
        tx_strobe_i = strobe;
        tick();
        wr_i        = 1'b0;
        tx_strobe_i = 1'b0;
    endtask

    task automatic streamStep(input logic wr, input logic [15:0] data, input logic strobe);
        if (wr) expQ.push_back(data);
        applyStimulus(wr, data, strobe);
        if (tx_valid_o) begin
            pairsSeen++;
            if (expQ.size() < 2) begin
                checkOutput("stream_scoreboard_empty", 32'(expQ.size()), 32'd2);
            end else begin
                logic [15:0] ei, eq;
                ei = expQ.pop_front();
                eq = expQ.pop_front();
                checkOutput("stream_pair", {tx_i_o, tx_q_o}, {ei, eq});
            end
        end
    endtask

    initial begin
        // Reset state
        tick();
        checkOutput("rst_tx_i", 32'(tx_i_o), 32'h0);
        checkOutput("rst_tx_q", 32'(tx_q_o), 32'h0);
        checkOutput("rst_valid", 32'(tx_valid_o), 32'h0);
        checkOutput("rst_underrun", 32'(tx_underrun_o), 32'h0);
        checkOutput("rst_fill", 32'(fill_o), 32'h0);
        checkOutput("rst_have_space", 32'(have_space_o), 32'h1);
        checkOutput("rst_debug", 32'(debug_o), 32'h0);
        rst_ni = 1'b1;
        tick();

        // Basic pair with exact latency
        applyStimulus(1'b1, 16'h1111, 1'b0);
        applyStimulus(1'b1, 16'h2222, 1'b0);
        checkOutput("fill_two", 32'(fill_o), 32'd2);
        applyStimulus(1'b0, 16'h0, 1'b1);
        checkOutput("valid_n1", 32'(tx_valid_o), 32'h0);
        tick();
        checkOutput("valid_n2", 32'(tx_valid_o), 32'h0);
        tick();
        checkOutput("valid_n3", 32'(tx_valid_o), 32'h1);
        checkOutput("pair_i", 32'(tx_i_o), 32'h1111);
        checkOutput("pair_q", 32'(tx_q_o), 32'h2222);
        checkOutput("pair_fill", 32'(fill_o), 32'd0);
        tick();
        checkOutput("valid_pulse_end", 32'(tx_valid_o), 32'h0);

        // Underrun on empty FIFO
        applyStimulus(1'b0, 16'h0, 1'b1);
        tick();
        checkOutput("under_valid", 32'(tx_valid_o), 32'h1);
        checkOutput("under_iq", {tx_i_o, tx_q_o}, 32'h0);
        checkOutput("under_flag", 32'(tx_underrun_o), 32'h1);
        checkOutput("under_fill", 32'(fill_o), 32'd0);
        tick();
        checkOutput("under_sticky", 32'(tx_underrun_o), 32'h1);
        clear_status_i = 1'b1;
        tick();
        clear_status_i = 1'b0;
        checkOutput("under_cleared", 32'(tx_underrun_o), 32'h0);

        // Underrun with a single stored word
        applyStimulus(1'b1, 16'h3333, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        tick();
        checkOutput("under1_valid", 32'(tx_valid_o), 32'h1);
        checkOutput("under1_iq", {tx_i_o, tx_q_o}, 32'h0);
        checkOutput("under1_flag", 32'(tx_underrun_o), 32'h1);
        checkOutput("under1_fill", 32'(fill_o), 32'd1);
        clear_status_i = 1'b1;
        tick();
        clear_status_i = 1'b0;
        checkOutput("under1_cleared", 32'(tx_underrun_o), 32'h0);

        // Clear coinciding with the UNDER cycle: set wins
        applyStimulus(1'b0, 16'h0, 1'b1);
        clear_status_i = 1'b1;
        tick();
        clear_status_i = 1'b0;
        checkOutput("set_wins_over_clear", 32'(tx_underrun_o), 32'h1);

        // Flush with simultaneous write; underrun survives flush
        applyStimulus(1'b1, 16'h4444, 1'b0);
        applyStimulus(1'b1, 16'h5555, 1'b0);
        checkOutput("pre_flush_fill", 32'(fill_o), 32'd3);
        flush_i = 1'b1;
        applyStimulus(1'b1, 16'h6666, 1'b0);
        flush_i = 1'b0;
        checkOutput("flush_fill", 32'(fill_o), 32'd0);
        checkOutput("flush_keeps_underrun", 32'(tx_underrun_o), 32'h1);
        clear_status_i = 1'b1;
        tick();
        clear_status_i = 1'b0;
        applyStimulus(1'b1, 16'hAAAA, 1'b0);
        applyStimulus(1'b1, 16'hBBBB, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        tick();
        tick();
        checkOutput("post_flush_valid", 32'(tx_valid_o), 32'h1);
        checkOutput("post_flush_pair", {tx_i_o, tx_q_o}, 32'hAAAABBBB);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checkOutput("flush_holds_outputs", {tx_i_o, tx_q_o}, 32'hAAAABBBB);

        // have_space threshold and full-drop
        for (int k = 0; k < 769; k++) applyStimulus(1'b1, 16'(k), 1'b0);
        checkOutput("fill_769", 32'(fill_o), 32'd769);
        checkOutput("have_space_lag", 32'(have_space_o), 32'h1);
        tick();
        checkOutput("have_space_drop", 32'(have_space_o), 32'h0);
        for (int k = 0; k < 255; k++) applyStimulus(1'b1, 16'(k), 1'b0);
        checkOutput("fill_full", 32'(fill_o), 32'd1024);
        applyStimulus(1'b1, 16'hDEAD, 1'b0);
        checkOutput("fill_full_drop", 32'(fill_o), 32'd1024);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checkOutput("flush_from_full", 32'(fill_o), 32'd0);
        tick();
        checkOutput("have_space_restored", 32'(have_space_o), 32'h1);

        // Streaming across pointer wrap
        for (int k = 0; k < 8; k++) streamStep(1'b1, 16'(k * 37 + 5), 1'b0);
        pairsSeen = 0;
        for (int s = 0; s < 520; s++) begin
            streamStep(1'b1, 16'((2 * s + 8) * 37 + 5), 1'b1);
            streamStep(1'b1, 16'((2 * s + 9) * 37 + 5), 1'b0);
            streamStep(1'b0, 16'h0, 1'b0);
            streamStep(1'b0, 16'h0, 1'b0);
        end
        checkOutput("stream_pairs", 32'(pairsSeen), 32'd520);
        checkOutput("stream_no_underrun", 32'(tx_underrun_o), 32'h0);
        checkOutput("stream_fill", 32'(fill_o), 32'd8);

        // Enable low: outputs zeroed, strobes ignored
        enable_i = 1'b0;
        tick();
        checkOutput("disable_zero", {tx_i_o, tx_q_o}, 32'h0);
        applyStimulus(1'b0, 16'h0, 1'b1);
        tick();
        tick();
        checkOutput("disable_no_valid", 32'(tx_valid_o), 32'h0);
        checkOutput("disable_fill", 32'(fill_o), 32'd8);
        enable_i = 1'b1;
        tick();

        // One more good pair, then reset during POP_Q
        begin
            logic [15:0] ei, eq;
            ei = expQ.pop_front();
            eq = expQ.pop_front();
            applyStimulus(1'b0, 16'h0, 1'b1);
            tick();
            tick();
            checkOutput("resume_pair", {tx_i_o, tx_q_o}, {ei, eq});
        end
        applyStimulus(1'b0, 16'h0, 1'b1);
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("midpop_rst_iq", {tx_i_o, tx_q_o}, 32'h0);
        checkOutput("midpop_rst_valid", 32'(tx_valid_o), 32'h0);
        checkOutput("midpop_rst_fill", 32'(fill_o), 32'd0);
        checkOutput("midpop_rst_have_space", 32'(have_space_o), 32'h1);
        tick();
        checkOutput("midpop_no_valid", 32'(tx_valid_o), 32'h0);
        rst_ni = 1'b1;
        tick();
        checkOutput("post_rst_valid", 32'(tx_valid_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
